hls_macc_lock_vec: RTL and testbench
====================================

// Module: hls_macc_lock_vec
// PURPOSE
//  Parametrised successor to the locked scalar MAC: a sequential N-lane multiply-accumulate
//  that computes out_acc = acc_i + sum(a[i]*b[i]) for i = 0..N-1, one product per cycle.
//  Uses the ap_ctrl_hs block handshake. A working_key de-obfuscates the operand datapath.
//  A correct key gives the golden result; any wrong key gives a corrupted but legal result.
//  Sits beside the other HLS kernels and is instantiated by the same locking wrapper flow.
// PARAMETERS
//  W        8     operand width (unsigned)
//  N        4     lane count, >= 1
//  ACC_W    18    accumulator/result width; default is 2*W+$clog2(N)
//  KEY_W    16    key width, = 2*W; bits [W-1:0] unmask a, bits [2W-1:W] unmask b
//  KEY_C    16'hA55A  embedded lock constant; the correct key equals KEY_C
// PORTS
//  ap_clk          in   1        clock, rising edge
//  ap_rst_n        in   1        asynchronous reset, active-low
//  ap_start        in   1        start request, sampled only in IDLE
//  ap_done         out  1        1-cycle pulse, result valid
//  ap_idle         out  1        high while in IDLE
//  ap_ready        out  1        1-cycle pulse, coincident with ap_done
//  in_a            in   N*W      packed lanes, lane i = in_a[i*W +: W]
//  in_b            in   N*W      packed lanes, same layout as in_a
//  acc_i           in   ACC_W    accumulator seed
//  working_key     in   KEY_W    unlock key
//  out_acc         out  ACC_W    result, registered
//  out_acc_ap_vld  out  1        high for the same cycle as ap_done
// BEHAVIOUR
//  - Reset (async assert, sync release): state=IDLE; out_acc=0; ap_done, ap_ready and
//    out_acc_ap_vld = 0; ap_idle = 1; lane counter = 0; operand and key registers = 0.
//  - FSM: IDLE -> CALC when ap_start=1. CALC lasts exactly N cycles, with lane counter 0..N-1.
//    CALC -> DONE when counter = N-1. DONE -> IDLE unconditionally.
//  - On IDLE & ap_start: capture in_a, in_b, acc_i and working_key; seed acc with acc_i.
//    Later input changes have no effect on the run in progress.
//  - CALC, each cycle: mask = key_r ^ KEY_C.
//    a_eff = a[cnt] ^ mask[W-1:0]; b_eff = b[cnt] ^ mask[2W-1:W].
//    acc <= acc + a_eff*b_eff. Use a 2W-bit product, zero-extend, add modulo 2^ACC_W
//    (wrap-around, no saturation, no overflow flag).
//  - DONE: out_acc holds the final acc. ap_done, ap_ready and out_acc_ap_vld are all 1 for
//    this one cycle. out_acc keeps its value until the next DONE or reset.
//  - Latency: start accepted at edge 0, DONE visible in cycle N+1. The earliest next start is
//    accepted in the IDLE cycle after DONE, so back-to-back period is N+2.
//  - ap_start held high continuously gives back-to-back runs. ap_start is ignored outside IDLE.
//  - N=1: CALC lasts 1 cycle, then DONE.
//  - Reset during CALC or DONE: abort immediately to reset values. No done pulse is emitted.
//  - Wrong key: same timing and handshake; only the value of out_acc differs.
// CONFIGURATION
//  MACC_KEY_LOCK_EN defined: masking applies as described above.
//  MACC_KEY_LOCK_EN undefined: mask is forced to 0, so the result is golden for any key.
//    working_key is then ignored but the port remains, and timing is identical.
// TESTING
//  1 reset: hold ap_rst_n=0 -> ap_idle=1, out_acc=0, all pulses 0; release -> still idle.
//  2 key=16'hA55A, a={4,3,2,1}, b={8,7,6,5} (lane3..0), acc_i=0 -> out_acc=70.
//    ap_done, ap_ready and vld all high in cycle 5 only.
//  3 same operands, acc_i=100 -> 170. Then a=b=all 255, acc_i=262143 -> 260099 (wrap).
//  4 key=16'h0000, operands as in 2 -> out_acc != 70 with timing identical.
//    With MACC_KEY_LOCK_EN undefined -> 70.
//  5 ap_start held high for 3 runs -> ap_done pulses at cycles 5, 11, 17.
//    Changing in_a mid-run does not alter that run's result.
//  6 ap_rst_n pulsed low during CALC lane 2 -> no ap_done, out_acc=0, ap_idle=1.
//    The next start gives a correct result.

Source files
------------

// File: rtl/hls_macc_lock_vec.sv
// Sequential N-lane multiply-accumulate with ap_ctrl_hs handshake and key-masked operands.
// Define MACC_KEY_LOCK_EN to enable operand masking; otherwise the key is ignored.
module hls_macc_lock_vec #(
    parameter int              W     = 8,
    parameter int              N     = 4,
    parameter int              ACC_W = 2*W + $clog2(N),
    parameter int              KEY_W = 2*W,
    parameter logic [KEY_W-1:0] KEY_C = KEY_W'(16'hA55A)
) (
    input  logic               ap_clk,
    input  logic               ap_rst_n,
    input  logic               ap_start,
    output logic               ap_done,
    output logic               ap_idle,
    output logic               ap_ready,
    input  logic [N*W-1:0]     in_a,
    input  logic [N*W-1:0]     in_b,
    input  logic [ACC_W-1:0]   acc_i,
    input  logic [KEY_W-1:0]   working_key,
    output logic [ACC_W-1:0]   out_acc,
    output logic               out_acc_ap_vld
);

    localparam int CNT_W = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_next;

    logic [N*W-1:0]     r_a;
    logic [N*W-1:0]     r_b;
    logic [KEY_W-1:0]   r_key;
    logic [ACC_W-1:0]   r_acc;
    logic [ACC_W-1:0]   r_out;
    logic [CNT_W-1:0]   r_cnt;

    logic [KEY_W-1:0]   w_mask;
    logic [W-1:0]       w_a_eff;
    logic [W-1:0]       w_b_eff;
    logic [ACC_W-1:0]   w_acc_nxt;
    logic               w_last;

    function automatic logic [W-1:0] f_lane(input logic [N*W-1:0] vec,
                                            input logic [CNT_W-1:0] idx);
        return vec[int'(idx)*W +: W];
    endfunction

    // Full-width unsigned product, zero-extended, accumulated modulo 2^ACC_W.
    function automatic logic [ACC_W-1:0] f_mac_wrap(input logic [ACC_W-1:0] acc,
                                                    input logic [W-1:0]     a,
                                                    input logic [W-1:0]     b);
        logic [2*W-1:0] prod;
        prod = {{W{1'b0}}, a} * {{W{1'b0}}, b};
        return acc + ACC_W'(prod);
    endfunction

`ifdef MACC_KEY_LOCK_EN
    assign w_mask = r_key ^ KEY_C;
`else
    logic w_unused_key;
    assign w_unused_key = ^r_key;
    assign w_mask       = '0;
`endif

    assign w_a_eff   = f_lane(r_a, r_cnt) ^ w_mask[W-1:0];
    assign w_b_eff   = f_lane(r_b, r_cnt) ^ w_mask[KEY_W-1:W];
    assign w_acc_nxt = f_mac_wrap(r_acc, w_a_eff, w_b_eff);
    assign w_last    = (r_cnt == CNT_W'(N-1));

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (ap_start) w_next = S_CALC;
            S_CALC:  if (w_last)   w_next = S_DONE;
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_comb begin
        ap_idle        = (r_state == S_IDLE);
        ap_done        = (r_state == S_DONE);
        ap_ready       = (r_state == S_DONE);
        out_acc_ap_vld = (r_state == S_DONE);
    end

    // Operands and key are frozen at start so later input changes cannot disturb a run.
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            r_a   <= '0;
            r_b   <= '0;
            r_key <= '0;
            r_acc <= '0;
            r_out <= '0;
            r_cnt <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (ap_start) begin
                        r_a   <= in_a;
                        r_b   <= in_b;
                        r_key <= working_key;
                        r_acc <= acc_i;
                        r_cnt <= '0;
                    end
                end
                S_CALC: begin
                    r_acc <= w_acc_nxt;
                    if (w_last) begin
                        r_out <= w_acc_nxt;
                        r_cnt <= '0;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign out_acc = r_out;

endmodule

// File: tb/tb_hls_macc_lock_vec.sv
// Scoreboard bench for hls_macc_lock_vec: expected results queued at start acceptance,
// popped and compared by a monitor whenever the DUT raises ap_done.
module tb_hls_macc_lock_vec;

    localparam int              W     = 8;
    localparam int              N     = 4;
    localparam int              ACC_W = 2*W + $clog2(N);
    localparam int              KEY_W = 2*W;
    localparam logic [KEY_W-1:0] KEY_C = 16'hA55A;

    logic               ap_clk = 1'b0;
    logic               ap_rst_n = 1'b0;
    logic               ap_start = 1'b0;
    logic               ap_done;
    logic               ap_idle;
    logic               ap_ready;
    logic [N*W-1:0]     in_a = '0;
    logic [N*W-1:0]     in_b = '0;
    logic [ACC_W-1:0]   acc_i = '0;
    logic [KEY_W-1:0]   working_key = '0;
    logic [ACC_W-1:0]   out_acc;
    logic               out_acc_ap_vld;

    hls_macc_lock_vec #(.W(W), .N(N), .ACC_W(ACC_W), .KEY_W(KEY_W), .KEY_C(KEY_C)) dut (
        .ap_clk         (ap_clk),
        .ap_rst_n       (ap_rst_n),
        .ap_start       (ap_start),
        .ap_done        (ap_done),
        .ap_idle        (ap_idle),
        .ap_ready       (ap_ready),
        .in_a           (in_a),
        .in_b           (in_b),
        .acc_i          (acc_i),
        .working_key    (working_key),
        .out_acc        (out_acc),
        .out_acc_ap_vld (out_acc_ap_vld)
    );

    always #5 ap_clk = ~ap_clk;

    typedef struct {
        logic [ACC_W-1:0] val;
        int               cyc;
    } exp_t;

    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   acc_cnt = 0;
    int   done_cnt = 0;
    exp_t sb_q[$];
    int   done_cyc_q[$];

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference: acc_i + sum over lanes of masked products, reduced modulo 2^ACC_W.
    function automatic logic [ACC_W-1:0] model(input logic [N*W-1:0]   a,
                                               input logic [N*W-1:0]   b,
                                               input logic [ACC_W-1:0] seed,
                                               input logic [KEY_W-1:0] key);
        logic [KEY_W-1:0] m;
        logic             lock;
        longint           sum;
        longint           ai;
        longint           bi;
`ifdef MACC_KEY_LOCK_EN
        lock = 1'b1;
`else
        lock = 1'b0;
`endif
        m   = lock ? (key ^ KEY_C) : '0;
        sum = longint'(seed);
        for (int i = 0; i < N; i++) begin
            ai  = longint'(a[i*W +: W] ^ m[W-1:0]);
            bi  = longint'(b[i*W +: W] ^ m[KEY_W-1:W]);
            sum = sum + ai * bi;
        end
        return sum[ACC_W-1:0];
    endfunction

    // Start acceptance: push the expected result and the cycle its done should appear in.
    always @(posedge ap_clk) begin
        cyc++;
        if (ap_rst_n && ap_idle && ap_start) begin
            sb_q.push_back('{model(in_a, in_b, acc_i, working_key), cyc + N});
            acc_cnt++;
        end
    end

    always @(negedge ap_clk) begin
        exp_t e;
        if (ap_rst_n) begin
            chk("ready_with_done", longint'(ap_ready), longint'(ap_done));
            chk("vld_with_done", longint'(out_acc_ap_vld), longint'(ap_done));
            if (ap_done) begin
                done_cnt++;
                done_cyc_q.push_back(cyc);
                chk("result_pending", longint'(sb_q.size() > 0), 1);
                if (sb_q.size() > 0) begin
                    e = sb_q.pop_front();
                    chk("out_acc", longint'(out_acc), longint'(e.val));
                    chk("done_cycle", longint'(cyc), longint'(e.cyc));
                    chk("idle_in_done", longint'(ap_idle), 0);
                end
            end
        end
    end

    task automatic wait_accept();
        int c0 = acc_cnt;
        for (int i = 0; i < 20 && acc_cnt == c0; i++) @(negedge ap_clk);
        chk("accept_timeout", longint'(acc_cnt != c0), 1);
    endtask

    task automatic wait_done();
        int d0 = done_cnt;
        for (int i = 0; i < 3*N + 10 && done_cnt == d0; i++) @(negedge ap_clk);
        chk("done_timeout", longint'(done_cnt != d0), 1);
    endtask

    task automatic do_run(input logic [N*W-1:0] a, input logic [N*W-1:0] b,
                          input logic [ACC_W-1:0] seed, input logic [KEY_W-1:0] key);
        @(negedge ap_clk);
        in_a        = a;
        in_b        = b;
        acc_i       = seed;
        working_key = key;
        ap_start    = 1'b1;
        wait_accept();
        ap_start = 1'b0;
        in_a     = $urandom;
        in_b     = $urandom;
        wait_done();
        @(negedge ap_clk);
    endtask

    localparam logic [N*W-1:0] A_T2 = {8'd4, 8'd3, 8'd2, 8'd1};
    localparam logic [N*W-1:0] B_T2 = {8'd8, 8'd7, 8'd6, 8'd5};

    initial begin
        int d0;
        int q0;
        logic [KEY_W-1:0] k;

        // Reset state
        ap_rst_n = 1'b0;
        ap_start = 1'b1;
        repeat (3) @(negedge ap_clk);
        chk("rst_idle", longint'(ap_idle), 1);
        chk("rst_out_acc", longint'(out_acc), 0);
        chk("rst_done", longint'(ap_done), 0);
        chk("rst_ready", longint'(ap_ready), 0);
        chk("rst_vld", longint'(out_acc_ap_vld), 0);
        ap_start = 1'b0;
        ap_rst_n = 1'b1;
        @(negedge ap_clk);
        chk("post_rst_idle", longint'(ap_idle), 1);
        chk("post_rst_done", longint'(ap_done), 0);

        // Golden key directed runs, including accumulator wrap-around
        do_run(A_T2, B_T2, '0, KEY_C);
        chk("t2_out", longint'(out_acc), 70);
        chk("t2_hold", longint'(out_acc), 70);
        do_run(A_T2, B_T2, ACC_W'(100), KEY_C);
        chk("t3_out", longint'(out_acc), 170);
        do_run({N*W{1'b1}}, {N*W{1'b1}}, ACC_W'(262143), KEY_C);
        chk("t3_wrap", longint'(out_acc), 260099);

        // Wrong key
        do_run(A_T2, B_T2, '0, '0);
`ifdef MACC_KEY_LOCK_EN
        chk("t4_corrupt", longint'(out_acc != ACC_W'(70)), 1);
`else
        chk("t4_unlocked", longint'(out_acc), 70);
`endif

        // Held start: three back-to-back runs with operands churning mid-run
        @(negedge ap_clk);
        d0 = done_cnt;
        q0 = done_cyc_q.size();
        in_a        = A_T2;
        in_b        = B_T2;
        acc_i       = '0;
        working_key = KEY_C;
        ap_start    = 1'b1;
        for (int i = 0; i < 60 && done_cnt < d0 + 3; i++) begin
            @(negedge ap_clk);
            in_a  = $urandom;
            in_b  = $urandom;
            acc_i = ACC_W'($urandom);
        end
        ap_start = 1'b0;
        chk("b2b_runs", longint'(done_cnt - d0), 3);
        if (done_cyc_q.size() >= q0 + 3) begin
            chk("b2b_period1", longint'(done_cyc_q[q0+1] - done_cyc_q[q0]), N + 2);
            chk("b2b_period2", longint'(done_cyc_q[q0+2] - done_cyc_q[q0+1]), N + 2);
        end
        repeat (2) @(negedge ap_clk);

        // Reset during CALC lane 2 aborts the run
        in_a        = A_T2;
        in_b        = B_T2;
        acc_i       = ACC_W'(5);
        working_key = KEY_C;
        ap_start    = 1'b1;
        wait_accept();
        ap_start = 1'b0;
        repeat (2) @(negedge ap_clk);
        d0 = done_cnt;
        ap_rst_n = 1'b0;
        sb_q.delete();
        #1;
        chk("abort_out_acc", longint'(out_acc), 0);
        chk("abort_idle", longint'(ap_idle), 1);
        chk("abort_done", longint'(ap_done), 0);
        repeat (2) @(negedge ap_clk);
        ap_rst_n = 1'b1;
        repeat (N + 4) @(negedge ap_clk);
        chk("abort_no_done", longint'(done_cnt), longint'(d0));
        chk("abort_still_idle", longint'(ap_idle), 1);
        do_run(A_T2, B_T2, '0, KEY_C);
        chk("after_abort_out", longint'(out_acc), 70);

        // Randomized runs, mixed correct and random keys
        for (int r = 0; r < 24; r++) begin
            k = ($urandom_range(0, 1) == 0) ? KEY_C : KEY_W'($urandom);
            do_run(N*W'($urandom), N*W'($urandom), ACC_W'($urandom), k);
        end

        repeat (4) @(negedge ap_clk);
        chk("sb_drained", longint'(sb_q.size()), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running, expected finished");
        $fatal(1, "timeout");
    end

endmodule
